// File: rtl/traffic_light_pkg.sv
// Shared light codes, phase encoding and default phase durations for the
// signal controller and its monitor.
package traffic_light_pkg;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;
    typedef enum logic {ACQUIRE, TRACK} mon_state_t;

    localparam int DEF_DUR_P0 = 8;
    localparam int DEF_DUR_P1 = 3;
    localparam int DEF_DUR_P2 = 10;
    localparam int DEF_DUR_P3 = 3;

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// Maps a {light_a, light_b} pair onto a phase; any pair outside the four
// legal combinations (including both roads non-red) is reported illegal.
module tl_phase_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] light_a,
    input  logic [2:0] light_b,
    output logic       legal,
    output phase_t     phase
);

    always_comb begin
        legal = 1'b1;
        phase = P0;
        case ({light_a, light_b})
            {LT_GREEN,  LT_RED}:    phase = P0;
            {LT_YELLOW, LT_RED}:    phase = P1;
            {LT_RED,    LT_GREEN}:  phase = P2;
            {LT_RED,    LT_YELLOW}: phase = P3;
            default:                legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the two-road light outputs: phase order, exact dwell
// times and illegal light codes, with sync status and a clean-cycle counter.
//
// state   | meaning
// ACQUIRE | not locked to the phase sequence; only illegal codes are flagged
// TRACK   | locked; phase order and dwell times are checked
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int DUR_P0        = DEF_DUR_P0,
    parameter int DUR_P1        = DEF_DUR_P1,
    parameter int DUR_P2        = DEF_DUR_P2,
    parameter int DUR_P3        = DEF_DUR_P3,
    parameter int CNT_W         = 5,
    parameter int CYC_W         = 8,
    parameter bit ALIGNED_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light_a,
    input  logic [2:0]       light_b,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             in_sync,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_dur,
    output logic             err_sticky,
    output logic [CYC_W-1:0] cycle_cnt
);

    logic [2:0]       a_q, b_q, prev_a, prev_b;
    logic             samp_v, have_prev, ovr_flag;
    logic [CNT_W-1:0] dwell, dwell_nxt;
    mon_state_t       state;
    phase_t           cur, exp_next, dec_phase;
    logic             dec_legal, change;
    logic             ill_nxt, seq_nxt, dur_nxt, cnt_inc, any_pulse;

    tl_phase_decode u_decode (
        .light_a (a_q),
        .light_b (b_q),
        .legal   (dec_legal),
        .phase   (dec_phase)
    );

    function automatic logic [CNT_W-1:0] dur_of(input phase_t p);
        case (p)
            P0:      return CNT_W'(DUR_P0);
            P1:      return CNT_W'(DUR_P1);
            P2:      return CNT_W'(DUR_P2);
            default: return CNT_W'(DUR_P3);
        endcase
    endfunction

    always_comb begin
        change    = !have_prev || (a_q != prev_a) || (b_q != prev_b);
        dwell_nxt = change ? CNT_W'(1) : ((dwell == '1) ? dwell : dwell + CNT_W'(1));
        ill_nxt   = 1'b0;
        seq_nxt   = 1'b0;
        dur_nxt   = 1'b0;
        cnt_inc   = 1'b0;
        if (samp_v) begin
            if (!dec_legal) begin
                ill_nxt = 1'b1;
            end else if (state == TRACK) begin
                if (change) begin
                    seq_nxt = (dec_phase != exp_next);
                    // an overrun already reported for this phase suppresses any further dwell flag
                    dur_nxt = have_prev && !ovr_flag && (dwell < dur_of(cur));
                    cnt_inc = (cur == P3) && (dec_phase == P0) && !seq_nxt && !dur_nxt;
                end else if (!ovr_flag && (dwell_nxt == dur_of(cur) + CNT_W'(1))) begin
                    dur_nxt = 1'b1;
                end
            end
        end
        any_pulse = ill_nxt | seq_nxt | dur_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            samp_v      <= 1'b0;
            prev_a      <= '0;
            prev_b      <= '0;
            have_prev   <= 1'b0;
            dwell       <= '0;
            ovr_flag    <= 1'b0;
            state       <= ALIGNED_RESET ? TRACK : ACQUIRE;
            cur         <= P0;
            exp_next    <= P0;
            phase       <= '0;
            phase_valid <= 1'b0;
            in_sync     <= 1'b0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_dur     <= 1'b0;
            err_sticky  <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            a_q         <= light_a;
            b_q         <= light_b;
            samp_v      <= 1'b1;
            err_illegal <= ill_nxt;
            err_seq     <= seq_nxt;
            err_dur     <= dur_nxt;
            err_sticky  <= clr_err ? any_pulse : (err_sticky | any_pulse);
            if (samp_v) begin
                prev_a    <= a_q;
                prev_b    <= b_q;
                have_prev <= 1'b1;
                dwell     <= dwell_nxt;
                if (cnt_inc) cycle_cnt <= cycle_cnt + CYC_W'(1);
                if (!dec_legal) begin
                    phase_valid <= 1'b0;
                    state       <= ACQUIRE;
                    in_sync     <= 1'b0;
                    ovr_flag    <= 1'b0;
                end else begin
                    phase_valid <= 1'b1;
                    phase       <= dec_phase;
                    case (state)
                        ACQUIRE: begin
                            if (change) begin
                                state    <= TRACK;
                                in_sync  <= 1'b1;
                                cur      <= dec_phase;
                                exp_next <= next_phase(dec_phase);
                                ovr_flag <= 1'b0;
                            end
                        end
                        default: begin
                            in_sync <= 1'b1;
                            if (change) begin
                                cur      <= dec_phase;
                                exp_next <= next_phase(dec_phase);
                                ovr_flag <= 1'b0;
                            end else if (dur_nxt) begin
                                ovr_flag <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench: runs of light pairs with hand-computed per-cycle pulse
// expectations, plus an asynchronous reset in the middle of a phase.
module tb_traffic_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] light_a = G;
    logic [2:0] light_b = R;
    logic       clr_err = 1'b0;
    logic [1:0] phase;
    logic       phase_valid, in_sync, err_illegal, err_seq, err_dur, err_sticky;
    logic [7:0] cycle_cnt;

    traffic_light_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .light_a     (light_a),
        .light_b     (light_b),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .in_sync     (in_sync),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_dur     (err_dur),
        .err_sticky  (err_sticky),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] la;
        logic [2:0] lb;
        int         len;
        int         ph;
        bit         pv;
        int         seq_at;
        int         dur_at;
        int         clr_at;
        bit         chk;
        bit         sync;
        int         cnt;
        bit         sticky;
    } rec_t;

    typedef struct {
        bit ill;
        bit seq;
        bit dur;
        int ph;
        bit pv;
        bit chk;
        bit sync;
        int cnt;
        bit sticky;
    } exp_t;

    rec_t recs[$];
    int   checks = 0;
    int   errors = 0;
    exp_t pend_e;
    bit   pend_v = 1'b0;
    bit   pend_clr = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_exp(input exp_t e);
        chk("err_illegal", int'(err_illegal), int'(e.ill));
        chk("err_seq", int'(err_seq), int'(e.seq));
        chk("err_dur", int'(err_dur), int'(e.dur));
        chk("phase", int'(phase), e.ph);
        chk("phase_valid", int'(phase_valid), int'(e.pv));
        if (e.chk) begin
            chk("in_sync", int'(in_sync), int'(e.sync));
            chk("cycle_cnt", int'(cycle_cnt), e.cnt);
            chk("err_sticky", int'(err_sticky), int'(e.sticky));
        end
    endtask

    // Outputs for a sample appear one call later; clr_err is delayed to the
    // same edge that evaluates the sample it is paired with.
    task automatic cyc(input logic [2:0] la, input logic [2:0] lb, input bit clr, input exp_t e);
        light_a = la;
        light_b = lb;
        clr_err = pend_clr;
        @(posedge clk);
        #1;
        if (pend_v) check_exp(pend_e);
        pend_e   = e;
        pend_v   = 1'b1;
        pend_clr = clr;
    endtask

    task automatic run_rec(input rec_t r);
        exp_t e;
        for (int i = 0; i < r.len; i++) begin
            e.ill    = !r.pv;
            e.seq    = (i == r.seq_at);
            e.dur    = (i == r.dur_at);
            e.ph     = r.ph;
            e.pv     = r.pv;
            e.chk    = r.chk && (i == r.len - 1);
            e.sync   = r.sync;
            e.cnt    = r.cnt;
            e.sticky = r.sticky;
            cyc(r.la, r.lb, (i == r.clr_at), e);
        end
    endtask

    task automatic add(input logic [2:0] la, input logic [2:0] lb, input int len, input int ph,
                       input bit pv, input int seq_at, input int dur_at, input int clr_at,
                       input bit c, input bit sync, input int cnt, input bit sticky);
        rec_t r;
        r = '{la, lb, len, ph, pv, seq_at, dur_at, clr_at, c, sync, cnt, sticky};
        recs.push_back(r);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_phase_valid"}, int'(phase_valid), 0);
        chk({tag, "_in_sync"}, int'(in_sync), 0);
        chk({tag, "_err_illegal"}, int'(err_illegal), 0);
        chk({tag, "_err_seq"}, int'(err_seq), 0);
        chk({tag, "_err_dur"}, int'(err_dur), 0);
        chk({tag, "_err_sticky"}, int'(err_sticky), 0);
        chk({tag, "_cycle_cnt"}, int'(cycle_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t dummy;
        dummy = '{0, 0, 0, 0, 1'b1, 0, 0, 0, 0};

        // nominal: four full loops into the fifth P0
        add(G, R, 8, 0, 1, -1, -1, -1, 1, 1, 0, 0);
        add(Y, R, 3, 1, 1, -1, -1, -1, 0, 0, 0, 0);
        add(R, G, 10, 2, 1, -1, -1, -1, 0, 0, 0, 0);
        add(R, Y, 3, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(G, R, 8, 0, 1, -1, -1, -1, 0, 0, 0, 0);
            add(Y, R, 3, 1, 1, -1, -1, -1, 0, 0, 0, 0);
            add(R, G, 10, 2, 1, -1, -1, -1, 0, 0, 0, 0);
            add(R, Y, 3, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        end
        add(G, R, 8, 0, 1, -1, -1, -1, 1, 1, 4, 0);
        // short P1: underrun flagged on the first P2 sample, loop still counted
        add(Y, R, 2, 1, 1, -1, -1, -1, 0, 0, 0, 0);
        add(R, G, 10, 2, 1, -1, 0, -1, 0, 0, 0, 0);
        add(R, Y, 3, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        add(G, R, 8, 0, 1, -1, -1, -1, 1, 1, 5, 1);
        add(Y, R, 3, 1, 1, -1, -1, 0, 1, 1, 5, 0);
        // long P0: single overrun at the 9th sample, none at the change
        add(R, G, 10, 2, 1, -1, -1, -1, 0, 0, 0, 0);
        add(R, Y, 3, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        add(G, R, 20, 0, 1, -1, 8, -1, 0, 0, 0, 0);
        add(Y, R, 3, 1, 1, -1, -1, -1, 1, 1, 6, 1);
        add(R, G, 10, 2, 1, -1, -1, 0, 0, 0, 0, 0);
        add(R, Y, 3, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        add(G, R, 8, 0, 1, -1, -1, -1, 1, 1, 7, 0);
        // skipped P1: one sequence error, rest of loop clean
        add(R, G, 10, 2, 1, 0, -1, -1, 0, 0, 0, 0);
        add(R, Y, 3, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        add(G, R, 8, 0, 1, -1, -1, -1, 1, 1, 8, 1);
        add(Y, R, 3, 1, 1, -1, -1, 0, 1, 1, 8, 0);
        // both roads green mid-P2, then reacquire on P2
        add(R, G, 4, 2, 1, -1, -1, -1, 0, 0, 0, 0);
        add(G, G, 2, 2, 0, -1, -1, -1, 1, 0, 8, 1);
        add(R, G, 10, 2, 1, -1, -1, -1, 1, 1, 8, 1);
        add(R, Y, 3, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        add(G, R, 8, 0, 1, -1, -1, -1, 1, 1, 9, 1);
        // short P3 with clr_err on the same edge as the underrun flag
        add(Y, R, 3, 1, 1, -1, -1, 0, 1, 1, 9, 0);
        add(R, G, 10, 2, 1, -1, -1, -1, 0, 0, 0, 0);
        add(R, Y, 2, 3, 1, -1, -1, -1, 0, 0, 0, 0);
        add(G, R, 8, 0, 1, -1, 0, 0, 1, 1, 9, 1);
        add(Y, R, 3, 1, 1, -1, -1, -1, 0, 0, 0, 0);
        add(R, G, 5, 2, 1, -1, -1, -1, 1, 1, 9, 1);

        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b1;

        foreach (recs[i]) run_rec(recs[i]);
        cyc(R, G, 1'b0, dummy);

        // asynchronous reset in the middle of P2
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        pend_v   = 1'b0;
        pend_clr = 1'b0;
        clr_err  = 1'b0;
        light_a  = G;
        light_b  = R;
        @(negedge clk);
        reset = 1'b1;
        run_rec('{G, R, 8, 0, 1, -1, -1, -1, 1, 1, 0, 0});
        run_rec('{Y, R, 3, 1, 1, -1, -1, -1, 1, 1, 0, 0});
        cyc(Y, R, 1'b0, dummy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
